multicycle_control: RTL and testbench

//   Main control FSM for the multicycle MIPS core. Decodes the IR opcode and

---
 rtl/multicycle_control.sv | 239 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Main control FSM of the multicycle MIPS core. It sequences the shared ALU,
//   register file, PC and unified memory through FETCH / DECODE / execute /
//   memory / writeback steps, decoded from the opcode held in IR. It also
//   counts retired instructions.
//
// Optional feature (compile-time macro ILLEGAL_TRAP_EN):
//   defined   : an unknown opcode in DECODE traps into HALT. HALT raises a
//               sticky `illegal` flag, drives every strobe low and is left
//               only through rst.
//   undefined : an unknown opcode behaves as a NOP. DECODE returns to FETCH,
//               the instruction is not counted, and `illegal` is tied to 0.
//
// Memory handshake:
//   memRead or memWrite is a request that the FSM holds for as long as the
//   memory state lasts. memReady=1 in a cycle means the memory completes that
//   request in the same cycle. The FSM advances out of FETCH / MEM_RD /
//   MEM_WR only on that cycle. The FETCH-side strobes (irWrite, pcWrite) are
//   asserted only when memReady=1, so IR and PC load exactly once.
//
// Ports:
//   clk, rst     core clock; synchronous active-high reset
//   opcode       IR[31:26], sampled in DECODE and MEM_ADDR only
//   memReady     memory completes the current request this cycle
//   pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
//   memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource
//                datapath controls (Moore decode of state; the FETCH-side
//                strobes are also qualified by memReady)
//   retired      instructions completed since reset (wraps at 2^CNT_W)
//   illegal      sticky illegal-opcode flag (0 unless ILLEGAL_TRAP_EN)
//   dbg_state    current FSM state, for observation only
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             pcWriteCond,
  output logic             iorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             memToReg,
  output logic             regDst,
  output logic             regWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [1:0]       pcSource,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic [3:0]       dbg_state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP
`ifdef ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_comb begin
    state_d     = state_q;
    retired_d   = retired_q;
    retire      = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSource    = 2'b00;
`ifdef ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif

    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        // PC+4 is computed on the ALU in the same cycle the IR loads.
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          aluSrcB = 2'b01;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        aluSrcB = 2'b11;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_EXEC_I;
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = S_HALT;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iorD    = 1'b1;
        memRead = 1'b1;
        if (memReady) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        memToReg = 1'b1;
        regWrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_MEM_WR: begin
        iorD     = 1'b1;
        memWrite = 1'b1;
        if (memReady) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_EXEC_I: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = S_I_WB;
      end
      S_I_WB: begin
        regWrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    if (retire) retired_d = retired_q + CNT_W'(1);

`ifdef ILLEGAL_TRAP_EN
    // Set on entry so the flag and HALT become visible in the same cycle.
    if (state_d == S_HALT) illegal_d = 1'b1;
`endif

    // A reset cycle must never commit anything to PC, IR, memory or regfile.
    if (rst) begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      irWrite     = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      regWrite    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign retired   = retired_q;
  assign dbg_state = state_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal   = illegal_q;
`else
  assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Drives instruction sequences (with random memory stalls) into the control
//   FSM. A reference model describes every instruction as its list of
//   architectural steps, and each step's control word is written straight from
//   the control table. The expected word is queued per cycle, and a negedge
//   monitor pops the queue and compares it with the DUT.
//   CNT_W is set to 4 so that retired-counter wrap is exercised.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int CNT_W = 4;
  localparam int W     = 17 + CNT_W;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef enum {
    K_FETCH_WAIT, K_FETCH, K_DEC, K_MADDR, K_MRD, K_MWB, K_MWR,
    K_EXR, K_RWB, K_EXI, K_IWB, K_BR, K_J, K_HALT
  } kind_t;

  // ---------------- clock / reset / DUT ----------------
  logic             clk;
  logic             rst;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic             memToReg, regDst, regWrite, aluSrcA;
  logic [1:0]       aluSrcB, aluOp, pcSource;
  logic [CNT_W-1:0] retired;
  logic             illegal;
  logic [3:0]       dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .memReady(mem_ready),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .retired(retired), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  logic [W-1:0] act;
  assign act = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
                pcSource, illegal, retired};

  // ---------------- reference model ----------------
  logic [W-1:0]     exp_q[$];
  string            tag_q[$];
  logic [CNT_W-1:0] model_ret;
  int               checks;
  int               errors;

  // Control word of one architectural step, taken from the control table.
  // During a reset cycle every read/write strobe is suppressed.
  function automatic logic [16:0] exp_ctrl(input kind_t k, input logic r);
    logic       pw = 0, pwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    logic       m2r = 0, rdst = 0, rw = 0, srca = 0, ill = 0;
    logic [1:0] srcb = 0, aop = 0, psrc = 0;
    case (k)
      K_FETCH_WAIT: mrd = 1;
      K_FETCH:      begin mrd = 1; irw = 1; pw = 1; srcb = 2'b01; end
      K_DEC:        srcb = 2'b11;
      K_MADDR:      begin srca = 1; srcb = 2'b10; end
      K_MRD:        begin iord = 1; mrd = 1; end
      K_MWB:        begin m2r = 1; rw = 1; end
      K_MWR:        begin iord = 1; mwr = 1; end
      K_EXR:        begin srca = 1; aop = 2'b10; end
      K_RWB:        begin rdst = 1; rw = 1; end
      K_EXI:        begin srca = 1; srcb = 2'b10; end
      K_IWB:        rw = 1;
      K_BR:         begin srca = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      K_J:          begin pw = 1; psrc = 2'b10; end
      K_HALT:       ill = 1;
      default:      ;
    endcase
    if (r) begin
      pw = 0; pwc = 0; irw = 0; mrd = 0; mwr = 0; rw = 0;
    end
    return {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop,
            psrc, ill};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- driver ----------------
  // One clock of stimulus: inputs change 1 time unit after the rising edge,
  // and the expected word for that cycle is queued.
  task automatic step(input kind_t k, input logic mr, input logic r,
                      input logic [5:0] op);
    @(posedge clk);
    #1;
    rst       = r;
    mem_ready = mr;
    opcode    = op;
    exp_q.push_back({exp_ctrl(k, r), model_ret});
    tag_q.push_back(k.name());
  endtask

  // fs: fetch stall cycles, ms: data-memory stall cycles,
  // abort: assert rst during the store's memory cycle.
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms,
                           input bit abort);
    for (int i = 0; i < fs; i++) step(K_FETCH_WAIT, 1'b0, 1'b0, 6'($urandom));
    step(K_FETCH, 1'b1, 1'b0, 6'($urandom));
    step(K_DEC, rnd_bit(), 1'b0, op);
    case (op)
      OP_R: begin
        step(K_EXR, rnd_bit(), 1'b0, op);
        step(K_RWB, rnd_bit(), 1'b0, op);
        model_ret++;
      end
      OP_ADDI: begin
        step(K_EXI, rnd_bit(), 1'b0, op);
        step(K_IWB, rnd_bit(), 1'b0, op);
        model_ret++;
      end
      OP_BEQ: begin
        step(K_BR, rnd_bit(), 1'b0, op);
        model_ret++;
      end
      OP_J: begin
        step(K_J, rnd_bit(), 1'b0, op);
        model_ret++;
      end
      OP_LW: begin
        step(K_MADDR, rnd_bit(), 1'b0, op);
        for (int i = 0; i < ms; i++) step(K_MRD, 1'b0, 1'b0, op);
        step(K_MRD, 1'b1, 1'b0, op);
        step(K_MWB, rnd_bit(), 1'b0, op);
        model_ret++;
      end
      OP_SW: begin
        step(K_MADDR, rnd_bit(), 1'b0, op);
        if (abort) begin
          // The memory even signals completion, but reset must win.
          step(K_MWR, 1'b1, 1'b1, op);
        end else begin
          for (int i = 0; i < ms; i++) step(K_MWR, 1'b0, 1'b0, op);
          step(K_MWR, 1'b1, 1'b0, op);
          model_ret++;
        end
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) step(K_HALT, rnd_bit(), 1'b0, op);
        step(K_HALT, rnd_bit(), 1'b1, op);
        model_ret = '0;
`endif
      end
    endcase
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    string        t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL step %s @%0t: dut ctrl=%05h ret=%0d, expected ctrl=%05h ret=%0d",
                 t, $time, act[W-1:CNT_W], act[CNT_W-1:0],
                 e[W-1:CNT_W], e[CNT_W-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] ops[7];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_BAD};
    checks    = 0;
    errors    = 0;
    model_ret = '0;
    rst       = 1'b1;
    mem_ready = 1'b0;
    opcode    = 6'b0;

    // Reset: FETCH with every strobe suppressed and the counter at zero.
    step(K_FETCH_WAIT, 1'b0, 1'b1, 6'b0);
    step(K_FETCH_WAIT, 1'b0, 1'b1, 6'b0);

    // Store aborted by reset in its memory cycle: no write, no count.
    run_instr(OP_SW, 0, 0, 1'b1);
    // Basic instructions, then lw with a 3-cycle memory stall.
    run_instr(OP_R,    0, 0, 1'b0);
    run_instr(OP_LW,   0, 3, 1'b0);
    run_instr(OP_BEQ,  0, 0, 1'b0);
    run_instr(OP_J,    0, 0, 1'b0);
    run_instr(OP_SW,   2, 2, 1'b0);
    run_instr(OP_BAD,  0, 0, 1'b0);
    // Sixteen addi wrap the 4-bit retired counter.
    for (int i = 0; i < 16; i++) run_instr(OP_ADDI, 0, 0, 1'b0);
    // Random mix with random stalls.
    for (int i = 0; i < 60; i++)
      run_instr(ops[$urandom_range(0, 6)], $urandom_range(0, 2),
                $urandom_range(0, 3), 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
